// File: rtl/dsp_pkg.sv
// Shared constants, FSM state type and index helpers for the NIRS DSP chain.
package dsp_pkg;
    localparam int DATLEN          = 12;
    localparam int NPTS            = 16;
    localparam int LOG2N           = 4;
    localparam int DEF_OUT_TIMEOUT = 256;
    localparam int CNT_W           = LOG2N + 1;

    typedef enum logic [1:0] {
        FILL,
        FEED,
        DRAIN
    } state_t;

    // Mirror the LOG2N-bit index so the core sees decimation-in-time order.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction
endpackage

// File: rtl/frame_buf.sv
// NPTS x DATLEN frame store: one write port, one registered read port.
module frame_buf
    import dsp_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [LOG2N-1:0]  wr_addr,
    input  logic [DATLEN-1:0] wr_data,
    input  logic              re,
    input  logic [LOG2N-1:0]  rd_addr,
    output logic [DATLEN-1:0] rd_data
);
    logic [DATLEN-1:0] mem [NPTS];

    // NOTE: the array is deliberately left without a reset; its contents are
    // don't-care after reset and a reset would turn it into NPTS*DATLEN reset flops.
    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Captures NPTS samples in bit-reversed order, bursts them into the FFT core,
// then counts output bins with timeout, overflow and dropped-sample tracking.
module fft_frame_sequencer
    import dsp_pkg::*;
#(
    parameter int OUT_TIMEOUT = DEF_OUT_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATLEN-1:0]   smp_data,
    input  logic                smp_vld,
    input  logic                clr_err,
    output logic [2*DATLEN-1:0] fft_in_x,
    output logic                fft_in_nd,
    input  logic                fft_out_nd,
    input  logic                fft_ovf,
    output logic                frm_start,
    output logic                bin_vld,
    output logic [LOG2N-1:0]    bin_idx,
    output logic                frm_done,
    output logic                err_ovf,
    output logic                err_tmo,
    output logic [7:0]          drop_cnt
);
    localparam int                TMO_W    = $clog2(OUT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NPTS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(OUT_TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  rcnt;
    logic [CNT_W-1:0]  ocnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [DATLEN-1:0] rd_data;
    logic [LOG2N-1:0]  wr_addr;
    logic              buf_we;
    logic              buf_re;
    logic              smp_drop;
    logic              ovf_hit;
    logic              tmo_hit;

    assign wr_addr  = bitrev(wcnt[LOG2N-1:0]);
    assign buf_we   = smp_vld && (state == FILL);
    assign buf_re   = (state == FEED);
    assign smp_drop = smp_vld && (state != FILL);
    assign ovf_hit  = fft_ovf && ((state == FEED) || (state == DRAIN));
    assign tmo_hit  = (state == DRAIN) && !fft_out_nd && (tmo_cnt == TMO_LAST);

    // The read register inside frame_buf is the output stage, so rcnt leads by one clock.
    assign fft_in_x = {{DATLEN{1'b0}}, rd_data};
    assign bin_vld  = fft_out_nd && (state == DRAIN);
    assign bin_idx  = ocnt[LOG2N-1:0];

    frame_buf u_frame_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (buf_we),
        .wr_addr (wr_addr),
        .wr_data (smp_data),
        .re      (buf_re),
        .rd_addr (rcnt[LOG2N-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FILL;
            wcnt      <= '0;
            rcnt      <= '0;
            ocnt      <= '0;
            tmo_cnt   <= '0;
            fft_in_nd <= 1'b0;
            frm_start <= 1'b0;
            frm_done  <= 1'b0;
        end else begin
            fft_in_nd <= (state == FEED);
            frm_start <= (state == FEED) && (rcnt == '0);
            frm_done  <= 1'b0;
            unique case (state)
                FILL: begin
                    if (smp_vld) begin
                        if (wcnt == LAST_IDX) begin
                            wcnt  <= '0;
                            rcnt  <= '0;
                            state <= FEED;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (rcnt == LAST_IDX) begin
                        rcnt    <= '0;
                        ocnt    <= '0;
                        tmo_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (fft_out_nd) begin
                        tmo_cnt <= '0;
                        if (ocnt == LAST_IDX) begin
                            ocnt     <= '0;
                            frm_done <= 1'b1;
                            state    <= FILL;
                        end else begin
                            ocnt <= ocnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Partial frame is abandoned; the next FILL starts clean.
                        tmo_cnt <= '0;
                        ocnt    <= '0;
                        state   <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Error flags: a set event in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_ovf  <= 1'b0;
            err_tmo  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (ovf_hit) begin
                err_ovf <= 1'b1;
            end else if (clr_err) begin
                err_ovf <= 1'b0;
            end

            if (tmo_hit) begin
                err_tmo <= 1'b1;
            end else if (clr_err) begin
                err_tmo <= 1'b0;
            end

            if (smp_drop) begin
                if (clr_err) begin
                    drop_cnt <= 8'd1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end else if (clr_err) begin
                drop_cnt <= '0;
            end
        end
    end
endmodule
